// File: rtl/elevator_scan_ctrl.sv
// Single-car elevator motion core: latches floor calls into a pending mask and
// serves them in SCAN order with modelled travel and door dwell times.
module elevator_scan_ctrl #(
   parameter int NUM_FLOORS    = 8,
   parameter int FLOOR_W       = $clog2(NUM_FLOORS),
   parameter int TRAVEL_CYCLES = 4,
   parameter int DOOR_CYCLES   = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_FLOORS-1:0] req,
   output logic [FLOOR_W-1:0]    floor,
   output logic                  dir,
   output logic                  moving,
   output logic                  door_open,
   output logic [NUM_FLOORS-1:0] pending
);

   localparam int TCW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
   localparam int DCW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
   localparam logic [TCW-1:0] TRAVEL_LAST = TCW'(TRAVEL_CYCLES - 1);
   localparam logic [DCW-1:0] DOOR_LAST   = DCW'(DOOR_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MOVE = 2'd1,
      ST_DOOR = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [FLOOR_W-1:0]    floor_q, floor_d;
   logic                  dir_q, dir_d;
   logic                  moving_q, moving_d;
   logic                  door_open_q, door_open_d;
   logic [NUM_FLOORS-1:0] pending_q, pending_d;
   logic [TCW-1:0]        tcnt_q, tcnt_d;
   logic [DCW-1:0]        dcnt_q, dcnt_d;
   logic [NUM_FLOORS-1:0] req_m_s;
   logic [NUM_FLOORS-1:0] clr_s;
   logic [FLOOR_W-1:0]    next_floor_s;

   function automatic logic [NUM_FLOORS-1:0] onehot(input logic [FLOOR_W-1:0] f);
      logic [NUM_FLOORS-1:0] r;
      r    = {NUM_FLOORS{1'b0}};
      r[f] = 1'b1;
      return r;
   endfunction

   function automatic logic any_above(input logic [NUM_FLOORS-1:0] p, input logic [FLOOR_W-1:0] f);
      logic r;
      r = 1'b0;
      for (int i = 0; i < NUM_FLOORS; i++) begin
         if (i > int'(f)) r = r | p[i];
         else             r = r;
      end
      return r;
   endfunction

   function automatic logic any_below(input logic [NUM_FLOORS-1:0] p, input logic [FLOOR_W-1:0] f);
      logic r;
      r = 1'b0;
      for (int i = 0; i < NUM_FLOORS; i++) begin
         if (i < int'(f)) r = r | p[i];
         else             r = r;
      end
      return r;
   endfunction

   // Next-state, pending-mask and output decode.
   always_comb begin
      state_d      = state_q;
      floor_d      = floor_q;
      dir_d        = dir_q;
      tcnt_d       = tcnt_q;
      dcnt_d       = dcnt_q;
      clr_s        = {NUM_FLOORS{1'b0}};
      next_floor_s = dir_q ? (floor_q - FLOOR_W'(1)) : (floor_q + FLOOR_W'(1));
      // A call for the floor whose door is already open is simply dropped.
      if (state_q == ST_DOOR) req_m_s = req & ~onehot(floor_q);
      else                    req_m_s = req;

      case (state_q)
         ST_IDLE: begin
            if (pending_q[floor_q]) begin
               state_d = ST_DOOR;
               clr_s   = onehot(floor_q);
               dcnt_d  = {DCW{1'b0}};
            end else if (!dir_q && any_above(pending_q, floor_q)) begin
               state_d = ST_MOVE;
               tcnt_d  = {TCW{1'b0}};
            end else if (dir_q && any_below(pending_q, floor_q)) begin
               state_d = ST_MOVE;
               tcnt_d  = {TCW{1'b0}};
            end else if (any_above(pending_q, floor_q)) begin
               state_d = ST_MOVE;
               dir_d   = 1'b0;
               tcnt_d  = {TCW{1'b0}};
            end else if (any_below(pending_q, floor_q)) begin
               state_d = ST_MOVE;
               dir_d   = 1'b1;
               tcnt_d  = {TCW{1'b0}};
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_MOVE: begin
            if (tcnt_q == TRAVEL_LAST) begin
               tcnt_d  = {TCW{1'b0}};
               floor_d = next_floor_s;
               if (pending_q[next_floor_s]) begin
                  state_d = ST_DOOR;
                  clr_s   = onehot(next_floor_s);
                  dcnt_d  = {DCW{1'b0}};
               end else if (dir_q ? any_below(pending_q, next_floor_s)
                                  : any_above(pending_q, next_floor_s)) begin
                  state_d = ST_MOVE;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               tcnt_d = tcnt_q + TCW'(1);
            end
         end
         ST_DOOR: begin
            if (dcnt_q == DOOR_LAST) begin
               dcnt_d  = {DCW{1'b0}};
               state_d = ST_IDLE;
            end else begin
               dcnt_d = dcnt_q + DCW'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      pending_d   = (pending_q | req_m_s) & ~clr_s;
      moving_d    = (state_d == ST_MOVE);
      door_open_d = (state_d == ST_DOOR);
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         floor_q     <= {FLOOR_W{1'b0}};
         dir_q       <= 1'b0;
         moving_q    <= 1'b0;
         door_open_q <= 1'b0;
         pending_q   <= {NUM_FLOORS{1'b0}};
         tcnt_q      <= {TCW{1'b0}};
         dcnt_q      <= {DCW{1'b0}};
      end else begin
         state_q     <= state_d;
         floor_q     <= floor_d;
         dir_q       <= dir_d;
         moving_q    <= moving_d;
         door_open_q <= door_open_d;
         pending_q   <= pending_d;
         tcnt_q      <= tcnt_d;
         dcnt_q      <= dcnt_d;
      end
   end

   assign floor     = floor_q;
   assign dir       = dir_q;
   assign moving    = moving_q;
   assign door_open = door_open_q;
   assign pending   = pending_q;

endmodule
